// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a_in, b_in, bin,
        input  busy, done, diff, bout, ovf
    );
    modport slave (
        input  start, a_in, b_in, bin,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a_in, b_in, bin,
        input  busy, done, diff, bout
    );
    modport slave (
        input  start, a_in, b_in, bin,
        output busy, done, diff, bout
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, one bit per clock.
// Optional two's-complement overflow flag enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic              br_q, br_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              cell_diff, cell_borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic              ovf_q, ovf_d;
`endif

    // Full-subtractor cell fed from the operand LSBs and the registered borrow.
    always_comb begin
        cell_diff   = sa_q[0] ^ sb_q[0] ^ br_q;
        cell_borrow = (~(sa_q[0] ^ sb_q[0]) & br_q) | (~sa_q[0] & sb_q[0]);
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sa_d    = bus.a_in;
                    sb_d    = bus.b_in;
                    br_d    = bus.bin;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = StShift;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = bus.a_in[WIDTH-1];
                    b_msb_d = bus.b_in[WIDTH-1];
`endif
                end
            end
            StShift: begin
                sa_d = sa_q >> 1;
                sb_d = sb_q >> 1;
                br_d = cell_borrow;
                sr_d = {cell_diff, sr_q[WIDTH-1:1]};
                if (count_q == CntLast) begin
                    // Last bit: publish the full result, counter is left at its final value.
                    diff_d  = {cell_diff, sr_q[WIDTH-1:1]};
                    bout_d  = cell_borrow;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
`endif
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: diff = a - b - bin.
- Built around the single-bit full-subtractor stage already in the design, which computes a^b^c and borrow (~(a^b)&c) | (~a&b).
- This block is the control and storage stage that feeds that cell one bit per clock, LSB first. It registers the borrow back into the cell's c input and collects the difference bits into a parallel result.
- Sits between parallel operand sources, such as switches or registers, and downstream display or compare logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request one subtraction; sampled only in IDLE
- a_in  input  WIDTH  minuend; captured on the accepted start edge
- b_in  input  WIDTH  subtrahend; captured on the accepted start edge
- bin  input  1  borrow-in; captured on the accepted start edge
- busy  output  1  high while bits are being shifted
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  difference; held until the next completion or reset
- bout  output  1  final borrow out; held with diff

Behaviour:
- One clock domain. Reset is synchronous and active-high. All state changes happen on the rising edge of clk.
- Reset values:
  - State = IDLE.
  - busy = 0, done = 0, diff = 0, bout = 0.
  - Internal shift registers, borrow register and bit counter = 0.
- States: IDLE and SHIFT.
- IDLE, with start = 1 at an edge:
  - Load a_in into sa and b_in into sb.
  - Load bin into the borrow register br.
  - Set count = 0 and busy = 1, then go to SHIFT.
  - With start = 0, hold all registers.
- SHIFT, each edge:
  - Feed the cell with a = sa[0], b = sb[0], c = br.
  - Shift sa and sb right by 1.
  - br <= cell borrow.
  - Shift the cell difference into the MSB of the internal result register sr (sr shifts right).
  - count <= count + 1.
- Completion:
  - On the edge where count == WIDTH-1, the last bit is processed.
  - On that edge, update diff from the completed sr value including this bit, set bout to the cell borrow, set done = 1 and busy = 0, and go to IDLE.
- Latency:
  - Start is accepted at edge E.
  - done is high during the cycle following edge E+WIDTH, and for exactly one cycle.
  - Throughput is one operation per WIDTH+1 cycles at best.
- start during SHIFT is ignored, and a_in, b_in and bin changes during SHIFT do not affect the result.
- start = 1 in the done cycle is accepted, because the state is IDLE. This allows back-to-back operations.
- diff and bout change only on the completion edge or on reset. They never show partial results.
- Arithmetic is unsigned modulo 2^WIDTH. bout = 1 exactly when a_in < b_in + bin as unsigned values.
- Reset mid-operation aborts the operation: no done pulse, and all outputs return to their reset values on that edge.
- The counter width is clog2(WIDTH) bits, and the counter never wraps past WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) and its register.
  - On the completion edge, ovf <= (a_msb != b_msb) && (diff_msb != a_msb). a_msb and b_msb are captured at start.
  - ovf is held with diff and reset to 0.
  - This is two's-complement overflow.
- Not defined:
  - No ovf port or logic exists.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, a_in=0x5A, b_in=0x23, bin=0, pulse start -> busy high 8 cycles; done pulse 1 cycle; diff=0x37, bout=0.
- a_in=0x10, b_in=0x20, bin=0 -> diff=0xF0, bout=1. a_in=0x00, b_in=0x00, bin=1 -> diff=0xFF, bout=1.
- Start accepted with a_in=0xFF, b_in=0x01; 3 cycles later pulse start and change a_in to 0x00 -> diff=0xFE, no second operation. Start held high in the done cycle with a_in=0x03, b_in=0x01 -> second done exactly 9 cycles later with diff=0x02.
- Assert rst for 1 cycle at the 4th SHIFT cycle of 0x5A-0x23 -> busy=0, diff=0x00, bout=0, no done pulse; a new start afterwards yields a correct 0x37.
- Previous result held: after the done for 0x5A-0x23, idle 20 cycles -> diff stays 0x37, done stays 0.
- With SERIAL_SUB_OVF_EN: 0x80-0x01 -> diff=0x7F, ovf=1, bout=0. 0x7F-0xFF -> diff=0x80, ovf=1, bout=1. 0x05-0x03 -> ovf=0.
